// File: rtl/slice_sequencer_param.sv
// Per-slice phase sequencer: walks DCT -> DC VLC -> AC VLC for one slice at a
// time. It drives the VLC stage resets, a slice-relative cycle counter, and
// done/error pulses. Phase lengths are parametrised. The block count is
// checked and latched at accept.
module slice_sequencer_param #(
  parameter int CNT_W        = 32,
  parameter int BLOCK_W      = 8,
  parameter int MAX_BLOCKS   = 32,
  parameter int DCT_TIME     = 12,
  parameter int DC_VLC_TIME  = 45,
  parameter int AC_PER_BLOCK = 63,
  parameter int AC_TAIL      = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               slice_start,
  input  logic [BLOCK_W-1:0] block_num,
  input  logic               slice_abort,
  output logic               slice_ready,
  output logic               slice_error,
  output logic [CNT_W-1:0]   sequence_counter,
  output logic               sequence_valid,
  output logic [1:0]         phase,
  output logic               dc_vlc_reset,
  output logic               ac_vlc_reset,
  output logic               slice_done
);

  // Phase lengths are held at BLOCK_W+7 bits, which is wide enough for
  // AC_PER_BLOCK*N + AC_TAIL.
  localparam int LEN_W = BLOCK_W + 7;

  // The encoding doubles as the phase output: 0=IDLE 1=DCT 2=DC_VLC 3=AC_VLC.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DCT    = 2'd1,
    ST_DC_VLC = 2'd2,
    ST_AC_VLC = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] ph_cnt_q, ph_cnt_d;   // cycles left in the current phase, minus one
  logic [LEN_W-1:0] l3_q, l3_d;           // AC VLC length latched at accept
  logic [CNT_W-1:0] seq_cnt_d;
  logic             valid_d, dc_rst_d, ac_rst_d, done_d, err_d;
  logic             n_legal;
  logic [LEN_W-1:0] l1_calc, l3_calc;

  assign slice_ready = (state_q == ST_IDLE);
  assign phase       = state_q;

  // Check the requested block count and derive its phase lengths.
  always_comb begin
    n_legal = (block_num != '0) && (int'(block_num) <= MAX_BLOCKS);
    l1_calc = LEN_W'(DCT_TIME) + LEN_W'(block_num);
    l3_calc = LEN_W'(AC_PER_BLOCK) * LEN_W'(block_num) + LEN_W'(AC_TAIL);
  end

  // Next-state and next-output decode. An abort in a busy state overrides everything else.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    l3_d      = l3_q;
    seq_cnt_d = sequence_counter;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if ((state_q != ST_IDLE) && slice_abort) begin
      state_d = ST_IDLE;
    end else begin
      if (sequence_valid) seq_cnt_d = sequence_counter + CNT_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (slice_start && !slice_abort) begin
            if (n_legal) begin
              state_d   = ST_DCT;
              ph_cnt_d  = l1_calc - LEN_W'(1);
              l3_d      = l3_calc;
              seq_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_DCT: begin
          if (ph_cnt_q == '0) begin
            state_d  = ST_DC_VLC;
            ph_cnt_d = LEN_W'(DC_VLC_TIME - 1);
          end else begin
            ph_cnt_d = ph_cnt_q - LEN_W'(1);
          end
        end
        ST_DC_VLC: begin
          if (ph_cnt_q == '0) begin
            state_d  = ST_AC_VLC;
            ph_cnt_d = l3_q - LEN_W'(1);
          end else begin
            ph_cnt_d = ph_cnt_q - LEN_W'(1);
          end
        end
        ST_AC_VLC: begin
          if (ph_cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ph_cnt_d = ph_cnt_q - LEN_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    valid_d  = (state_d != ST_IDLE);
    dc_rst_d = (state_d != ST_DC_VLC);
    ac_rst_d = (state_d != ST_AC_VLC);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make every register here sample pre-edge values, whatever the statement order.
    if (reset) begin
      state_q          <= ST_IDLE;
      ph_cnt_q         <= '0;
      l3_q             <= '0;
      sequence_counter <= '0;
      sequence_valid   <= 1'b0;
      dc_vlc_reset     <= 1'b1;
      ac_vlc_reset     <= 1'b1;
      slice_done       <= 1'b0;
      slice_error      <= 1'b0;
    end else begin
      state_q          <= state_d;
      ph_cnt_q         <= ph_cnt_d;
      l3_q             <= l3_d;
      sequence_counter <= seq_cnt_d;
      sequence_valid   <= valid_d;
      dc_vlc_reset     <= dc_rst_d;
      ac_vlc_reset     <= ac_rst_d;
      slice_done       <= done_d;
      slice_error      <= err_d;
    end
  end

endmodule

// File: tb/tb_slice_sequencer_param.sv
// Bench for slice_sequencer_param. It compares the DUT against a model that
// tracks a slice as "cycles since accept". The phase is derived from the
// slice's lengths with plain arithmetic.
module tb_slice_sequencer_param;

  localparam int CNT_W        = 32;
  localparam int BLOCK_W      = 8;
  localparam int MAX_BLOCKS   = 32;
  localparam int DCT_TIME     = 12;
  localparam int DC_VLC_TIME  = 45;
  localparam int AC_PER_BLOCK = 63;
  localparam int AC_TAIL      = 5;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               slice_start = 1'b0;
  logic [BLOCK_W-1:0] block_num = '0;
  logic               slice_abort = 1'b0;
  logic               slice_ready, slice_error, sequence_valid;
  logic               dc_vlc_reset, ac_vlc_reset, slice_done;
  logic [CNT_W-1:0]   sequence_counter;
  logic [1:0]         phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_err  = 1'b0;
  int               m_t    = 0;      // cycles since accept
  int               m_l1   = 0;      // DCT length of the current slice
  int               m_end  = 0;      // total slice length T
  logic [CNT_W-1:0] m_cnt  = '0;

  slice_sequencer_param #(
    .CNT_W(CNT_W), .BLOCK_W(BLOCK_W), .MAX_BLOCKS(MAX_BLOCKS), .DCT_TIME(DCT_TIME),
    .DC_VLC_TIME(DC_VLC_TIME), .AC_PER_BLOCK(AC_PER_BLOCK), .AC_TAIL(AC_TAIL)
  ) dut (
    .clock(clock), .reset(reset), .slice_start(slice_start), .block_num(block_num),
    .slice_abort(slice_abort), .slice_ready(slice_ready), .slice_error(slice_error),
    .sequence_counter(sequence_counter), .sequence_valid(sequence_valid), .phase(phase),
    .dc_vlc_reset(dc_vlc_reset), .ac_vlc_reset(ac_vlc_reset), .slice_done(slice_done)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] m_phase();
    if (!m_busy) return 2'd0;
    if (m_t < m_l1) return 2'd1;
    if (m_t < m_l1 + DC_VLC_TIME) return 2'd2;
    return 2'd3;
  endfunction

  // {ready, error, done, valid, dc_reset, ac_reset, phase, counter}
  function automatic logic [39:0] exp_vec();
    logic [1:0] p;
    p = m_phase();
    return {!m_busy, m_err, m_done, m_busy, (p != 2'd2), (p != 2'd3), p, m_cnt};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {slice_ready, slice_error, slice_done, sequence_valid, dc_vlc_reset,
            ac_vlc_reset, phase, sequence_counter};
  endfunction

  // Advance the model by one edge, using the inputs the DUT sees at that edge.
  task automatic model_edge();
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_busy) begin
        if (slice_abort) begin
          m_busy = 1'b0;
        end else begin
          m_t++;
          m_cnt++;
          if (m_t == m_end) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (slice_start && !slice_abort) begin
        if (block_num >= 1 && int'(block_num) <= MAX_BLOCKS) begin
          m_busy = 1'b1;
          m_t    = 0;
          m_cnt  = '0;
          m_l1   = DCT_TIME + int'(block_num);
          m_end  = m_l1 + DC_VLC_TIME + AC_PER_BLOCK * int'(block_num) + AC_TAIL;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_n4();
    int dc_low = 0, ac_low = 0, first_dc = -1, done_cnt = -1;
    block_num = 8'd4; slice_start = 1'b1;
    step();
    slice_start = 1'b0; block_num = 8'hA5;   // later changes must not matter
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL n4_accept cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
    for (int i = 0; i < 400; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL n4_run cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (!dc_vlc_reset) begin
        dc_low++;
        if (first_dc < 0) first_dc = int'(sequence_counter);
      end
      if (!ac_vlc_reset) ac_low++;
      if (slice_done) begin
        done_cnt = int'(sequence_counter);
        break;
      end
    end
    total++;
    if (first_dc != DCT_TIME + 4) begin
      bad++; $display("FAIL n4_dc_start got=%0d want=%0d", first_dc, DCT_TIME + 4);
    end
    total++;
    if (dc_low != DC_VLC_TIME) begin
      bad++; $display("FAIL n4_dc_len got=%0d want=%0d", dc_low, DC_VLC_TIME);
    end
    total++;
    if (ac_low != AC_PER_BLOCK * 4 + AC_TAIL) begin
      bad++; $display("FAIL n4_ac_len got=%0d want=%0d", ac_low, AC_PER_BLOCK * 4 + AC_TAIL);
    end
    total++;
    if (done_cnt != 318) begin
      bad++; $display("FAIL n4_done_count got=%0d want=318", done_cnt);
    end
    step();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL n4_idle cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int first_dc = -1, done_cnt = -1;
    bit seen_done = 1'b0;
    block_num = 8'd1; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b_first cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (slice_done) begin
        seen_done = 1'b1;
        break;
      end
    end
    total++;
    if (!seen_done || slice_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready_at_done done=%0b ready=%b want 1/1", seen_done, slice_ready);
    end
    block_num = 8'd32; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    total++;
    if (phase !== 2'd1 || sequence_counter !== '0 || sequence_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_accept phase=%0d count=%0d valid=%b want 1/0/1",
                      phase, sequence_counter, sequence_valid);
    end
    for (int i = 0; i < 2300; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b_second cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (!dc_vlc_reset && first_dc < 0) first_dc = int'(sequence_counter);
      if (slice_done) begin
        done_cnt = int'(sequence_counter);
        break;
      end
    end
    total++;
    if (first_dc != 44) begin
      bad++; $display("FAIL b2b_dc_start got=%0d want=44", first_dc);
    end
    total++;
    if (done_cnt != 44 + DC_VLC_TIME + AC_PER_BLOCK * 32 + AC_TAIL) begin
      bad++; $display("FAIL b2b_total got=%0d want=%0d", done_cnt,
                      44 + DC_VLC_TIME + AC_PER_BLOCK * 32 + AC_TAIL);
    end
  endtask

  task automatic test_error();
    logic [BLOCK_W-1:0] bad_n [2];
    bad_n[0] = 8'd0;
    bad_n[1] = 8'd33;
    for (int k = 0; k < 2; k++) begin
      block_num = bad_n[k]; slice_start = 1'b1;
      step();
      slice_start = 1'b0;
      total++;
      if (obs_vec() !== exp_vec() || slice_error !== 1'b1 || phase !== 2'd0) begin
        bad++; $display("FAIL err_pulse n=%0d got=%h want=%h", bad_n[k], obs_vec(), exp_vec());
      end
      step();
      total++;
      if (obs_vec() !== exp_vec() || slice_error !== 1'b0) begin
        bad++; $display("FAIL err_clear n=%0d got=%h want=%h", bad_n[k], obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort();
    block_num = 8'd4; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    for (int i = 0; i < 200 && sequence_counter != 100; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL abort_run cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    slice_abort = 1'b1; slice_start = 1'b1;
    step();
    slice_abort = 1'b0; slice_start = 1'b0;
    total++;
    if (phase !== 2'd0 || sequence_counter !== 32'd100 || slice_done !== 1'b0 ||
        dc_vlc_reset !== 1'b1 || ac_vlc_reset !== 1'b1 || sequence_valid !== 1'b0) begin
      bad++; $display("FAIL abort_state got=%h want phase0 count100 resets1 valid0 done0", obs_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL abort_after cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ignored_starts();
    int done_cnt = -1;
    block_num = 8'd3; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    step(); step();
    block_num = 8'd20; slice_start = 1'b1;   // busy: must be dropped
    step();
    slice_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL busy_start cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (slice_done) begin
        done_cnt = int'(sequence_counter);
        break;
      end
    end
    total++;
    if (done_cnt != DCT_TIME + 3 + DC_VLC_TIME + AC_PER_BLOCK * 3 + AC_TAIL) begin
      bad++; $display("FAIL busy_start_total got=%0d want=%0d", done_cnt,
                      DCT_TIME + 3 + DC_VLC_TIME + AC_PER_BLOCK * 3 + AC_TAIL);
    end
    block_num = 8'd5; slice_start = 1'b1; slice_abort = 1'b1;
    step();
    slice_start = 1'b0; slice_abort = 1'b0;
    total++;
    if (obs_vec() !== exp_vec() || phase !== 2'd0 || slice_error !== 1'b0) begin
      bad++; $display("FAIL start_with_abort got=%h want=%h", obs_vec(), exp_vec());
    end
    slice_abort = 1'b1;
    step();
    slice_abort = 1'b0;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL idle_abort got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_slice();
    int done_cnt = -1;
    block_num = 8'd8; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    for (int i = 0; i < 100 && !(phase == 2'd2 && sequence_counter >= 25); i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (obs_vec() !== exp_vec() || phase !== 2'd0 || sequence_counter !== '0 ||
        dc_vlc_reset !== 1'b1 || sequence_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%h want=%h", obs_vec(), exp_vec());
    end
    block_num = 8'd2; slice_start = 1'b1;
    step();
    slice_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL post_reset cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (slice_done) begin
        done_cnt = int'(sequence_counter);
        break;
      end
    end
    total++;
    if (done_cnt != DCT_TIME + 2 + DC_VLC_TIME + AC_PER_BLOCK * 2 + AC_TAIL) begin
      bad++; $display("FAIL post_reset_total got=%0d want=%0d", done_cnt,
                      DCT_TIME + 2 + DC_VLC_TIME + AC_PER_BLOCK * 2 + AC_TAIL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8000; i++) begin
      slice_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) block_num = BLOCK_W'($urandom_range(0, 40));
      else                            block_num = BLOCK_W'($urandom_range(1, 6));
      slice_abort = ($urandom_range(0, 199) == 0);
      reset       = ($urandom_range(0, 2999) == 0);
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cycle=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    slice_start = 1'b0; slice_abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_n4();
    test_back_to_back();
    test_error();
    test_abort();
    test_ignored_starts();
    test_reset_mid_slice();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
